// File: rtl/nibble_serial_adder.sv
// Nibble-serial W-bit adder sequencer driving an external combinational 4-bit adder.
// Latency: operand accepted at edge k, result valid after edge k+NIBBLES (one nibble per cycle).
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready, one operation in flight.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4*NIBBLES-1:0] i_op_a,
  input  logic [4*NIBBLES-1:0] i_op_b,
  input  logic                 i_cin,
  output logic [3:0]           o_add_a,
  output logic [3:0]           o_add_b,
  output logic                 o_add_c,
  input  logic [3:0]           i_add_sum,
  input  logic                 i_add_carry,
  input  logic                 i_add_over,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [4*NIBBLES-1:0] o_result,
  output logic                 o_carry,
  output logic                 o_over
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic [W-1:0]    result_q;
  logic            cy_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            over_q;

  logic [CW-1:0]   cnt_d;
  logic            last_d;
  logic            run;

  // Next nibble index and "this is the top nibble" decode
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    last_d = (cnt_q == CW'(NIBBLES - 1));
  end

  // Sequencer: load operands, ripple one nibble per cycle, hold result until taken
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_a_q  <= i_op_a;
            op_b_q  <= i_op_b;
            cy_q    <= i_cin;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[{cnt_q, 2'b00} +: 4] <= i_add_sum;
          cy_q   <= i_add_carry;
          op_a_q <= {4'h0, op_a_q[W-1:4]};
          op_b_q <= {4'h0, op_b_q[W-1:4]};
          if (last_d) begin
            // Top nibble: its carry and signed overflow describe the whole word
            carry_q <= i_add_carry;
            over_q  <= i_add_over;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake and adder drive are decoded from registered state only
  always_comb begin
    run      = (state_q == S_RUN);
    o_ready  = (state_q == S_IDLE) && !i_rst;
    o_valid  = (state_q == S_DONE);
    o_add_a  = run ? op_a_q[3:0] : 4'h0;
    o_add_b  = run ? op_b_q[3:0] : 4'h0;
    o_add_c  = run ? cy_q : 1'b0;
    o_result = result_q;
    o_carry  = carry_q;
    o_over   = over_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder with a behavioural 4-bit adder
// and a whole-word arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_op_a = '0;
  logic [W-1:0] i_op_b = '0;
  logic         i_cin = 1'b0;
  logic [3:0]   o_add_a;
  logic [3:0]   o_add_b;
  logic         o_add_c;
  logic [3:0]   i_add_sum;
  logic         i_add_carry;
  logic         i_add_over;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_result;
  logic         o_carry;
  logic         o_over;

  int tests_run = 0;
  int tests_failed = 0;
  int idle_add_viol = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_cin(i_cin),
    .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_c(o_add_c),
    .i_add_sum(i_add_sum), .i_add_carry(i_add_carry), .i_add_over(i_add_over),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_carry(o_carry), .o_over(o_over)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural combinational 4-bit adder
  always_comb begin
    logic [4:0] s;
    s = {1'b0, o_add_a} + {1'b0, o_add_b} + {4'h0, o_add_c};
    i_add_sum   = s[3:0];
    i_add_carry = s[4];
    i_add_over  = (o_add_a[3] == o_add_b[3]) && (s[3] != o_add_a[3]);
  end

  // Outside RUN (ready or valid shown) the adder inputs must be quiet
  always @(negedge i_clk) begin
    if (!i_rst && (o_ready || o_valid) && (o_add_a != 4'h0 || o_add_b != 4'h0 || o_add_c != 1'b0))
      idle_add_viol++;
    if (o_ready && o_valid)
      idle_add_viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain W-bit arithmetic
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {v, s};
  endfunction

  // Carry entering nibble j of the word add
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int j);
    longint unsigned m, s;
    if (j == 0) return c;
    m = (64'd1 << (4 * j)) - 1;
    s = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
    return s[4 * j];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("wait_ready", 64'(o_ready), 64'd1);
  endtask

  // One operation: drive, check per-nibble adder drive and latency, hold, consume
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int hold);
    logic [W+1:0] e;
    int cyc;
    e = ref_add(a, b, c);
    wait_ready();
    i_op_a = a; i_op_b = b; i_cin = c; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    cyc = 0;
    while (!o_valid && cyc < 40) begin
      if (cyc < N) begin
        check("add_a", 64'(o_add_a), 64'(a[4*cyc +: 4]));
        check("add_b", 64'(o_add_b), 64'(b[4*cyc +: 4]));
        check("add_c", 64'(o_add_c), 64'(carry_into(a, b, c, cyc)));
      end
      @(negedge i_clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(N));
    check("result", 64'(o_result), 64'(e[W-1:0]));
    check("carry", 64'(o_carry), 64'(e[W]));
    check("over", 64'(o_over), 64'(e[W+1]));
    for (int h = 0; h < hold; h++) begin
      // A request arriving while the result is held must be ignored
      i_valid = (h == 1);
      i_op_a  = ~a;
      i_op_b  = 16'h1111;
      @(negedge i_clk);
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_ready", 64'(o_ready), 64'd0);
      check("hold_result", 64'(o_result), 64'(e[W-1:0]));
      check("hold_flags", 64'({o_carry, o_over}), 64'({e[W], e[W+1]}));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check("valid_drop", 64'(o_valid), 64'd0);
    check("idle_keeps_result", 64'(o_result), 64'(e[W-1:0]));
  endtask

  logic [W-1:0] dir_a [6] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h7FFF, 16'h8000, 16'h0000};
  logic [W-1:0] dir_b [6] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0000};
  logic         dir_c [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] dir_r [6] = '{16'h5555, 16'h0000, 16'h0100, 16'h8000, 16'h0000, 16'h0001};
  logic         dir_co[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         dir_v [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic [W+1:0] e;
    int cyc;

    // Reset state
    #12;
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    check("rst_flags", 64'({o_carry, o_over}), 64'd0);
    check("rst_add", 64'({o_add_a, o_add_b, o_add_c}), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1 check("post_rst_ready", 64'(o_ready), 64'd1);

    // Directed vectors, with backpressure on the first one
    for (int i = 0; i < 6; i++) begin
      do_op(dir_a[i], dir_b[i], dir_c[i], (i == 0) ? 5 : 0);
      check("dir_result", 64'(o_result), 64'(dir_r[i]));
      check("dir_flags", 64'({o_carry, o_over}), 64'({dir_co[i], dir_v[i]}));
    end

    // Asynchronous reset mid-RUN after two nibbles
    wait_ready();
    i_op_a = 16'h9ABC; i_op_b = 16'h5678; i_cin = 1'b1; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_ready", 64'(o_ready), 64'd0);
    check("mid_rst_result", 64'(o_result), 64'd0);
    check("mid_rst_add", 64'({o_add_a, o_add_b, o_add_c}), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1 check("mid_rst_release_ready", 64'(o_ready), 64'd1);
    do_op(16'h0001, 16'h0001, 1'b0, 0);
    check("after_rst_result", 64'(o_result), 64'h0002);

    // Back-to-back with i_valid held high across three operations
    ba = '{16'hA5A5, 16'h0F0F, 16'hFFFE};
    bb = '{16'h5A5A, 16'hF0F1, 16'h0003};
    wait_ready();
    i_op_a = ba[0]; i_op_b = bb[0]; i_cin = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = ref_add(ba[k], bb[k], 1'b0);
      wait_ready();
      @(posedge i_clk);
      @(negedge i_clk);
      if (k < 2) begin
        i_op_a = ba[k+1]; i_op_b = bb[k+1];
      end else begin
        i_valid = 1'b0;
      end
      cyc = 0;
      while (!o_valid && cyc < 40) begin
        @(negedge i_clk);
        cyc++;
      end
      check("b2b_latency", 64'(cyc), 64'(N));
      check("b2b_result", 64'(o_result), 64'(e[W-1:0]));
      check("b2b_flags", 64'({o_carry, o_over}), 64'({e[W], e[W+1]}));
      i_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_ready = 1'b0;
    end

    // Randomized operations with random result backpressure
    for (int r = 0; r < 30; r++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    check("add_quiet_outside_run", 64'(idle_add_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequencer that adds two NIBBLES*4-bit operands nibble-serially through the team's external combinational 4-bit adder stage. It sits directly upstream of the adder, driving its a/b/carry-in inputs, and consumes the adder's sum/carry/overflow outputs. Operands enter and results leave through valid/ready handshakes. The block processes one operation at a time.

Parameters:
NIBBLES, 4, number of 4-bit digits per operand; operand/result width W = 4*NIBBLES; legal range 2..16.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_valid  input  1  operand request valid
o_ready  output  1  block can accept operands
i_op_a  input  W  operand A
i_op_b  input  W  operand B
i_cin  input  1  carry-in to bit 0 of the whole word
o_add_a  output  4  nibble A to the adder
o_add_b  output  4  nibble B to the adder
o_add_c  output  1  carry-in to the adder
i_add_sum  input  4  adder sum nibble
i_add_carry  input  1  adder carry-out
i_add_over  input  1  adder signed overflow of the current nibble
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_result  output  W  sum, registered
o_carry  output  1  final carry-out of the word
o_over  output  1  signed overflow of the whole W-bit add (from the top nibble)

Behaviour:
- Single clock domain. i_rst is asynchronous, active-high: it forces state IDLE and clears all registers to 0. Reset values: o_valid=0, o_result=0, o_carry=0, o_over=0, o_add_a=0, o_add_b=0, o_add_c=0. o_ready=0 while i_rst=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - If i_valid=1 at a clock edge: latch i_op_a and i_op_b into shift registers, latch i_cin into the carry register, clear the nibble counter, go to RUN.
- RUN:
  - o_ready=0.
  - Adder outputs: o_add_a and o_add_b are the low nibbles of the shift registers (LSB nibble first); o_add_c is the carry register. These are registered-state-driven, not dependent on adder inputs.
  - Each edge in RUN:
    - Shift i_add_sum into the result register at nibble position cnt.
    - Carry register <= i_add_carry.
    - Shift the operand registers right by 4.
    - cnt <= cnt+1.
  - On the edge where cnt==NIBBLES-1: o_carry <= i_add_carry, o_over <= i_add_over, go to DONE.
- DONE:
  - o_valid=1. o_result, o_carry and o_over are held stable.
  - If i_ready=1 at an edge: go to IDLE, o_valid drops next cycle.
  - o_ready=0, so no overlap between operations.
- Latency: operand accepted at edge k; o_valid=1 in the cycle after edge k+NIBBLES. Throughput is at most one op per NIBBLES+2 cycles.
- o_add_* are 0 in IDLE and DONE.
- i_valid in RUN or DONE is ignored. The upstream source must hold its request until it sees o_ready.
- Result fields are updated only in RUN. The previous result stays visible on o_result after returning to IDLE until the next op overwrites it nibble by nibble; o_valid is the sole qualifier.
- Wrap-around: the W-bit sum is modulo 2^W; the carry-out appears only on o_carry.
- Reset mid-RUN or mid-DONE: immediate return to IDLE, partial result discarded, o_valid=0.
- Counter width is clog2(NIBBLES). The counter never exceeds NIBBLES-1.
- Adder contract: combinational, sum = a + b + c with carry and signed overflow. The bench uses a behavioural model of this adder.

Test Plan:
- NIBBLES=4, 0x1234 + 0x4321, cin=0 -> o_result=0x5555, o_carry=0, o_over=0; o_valid rises 4 cycles after acceptance.
- 0xFFFF + 0x0001, cin=0 -> 0x0000, c=1, v=0. Then 0x00FF + 0x0000, cin=1 -> 0x0100, c=0, v=0 (carry ripples across nibbles).
- 0x7FFF + 0x0001 -> 0x8000, c=0, v=1. 0x8000 + 0x8000 -> 0x0000, c=1, v=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid, o_result, o_carry, o_over stable; o_ready=0 throughout. A new i_valid pulse during this time is not accepted.
- Assert i_rst asynchronously (mid-cycle) in RUN after 2 nibbles -> outputs 0 immediately. After release, o_ready=1; the next op 0x0001 + 0x0001 gives 0x0002 with no residue.
- Back-to-back i_valid held high for 3 ops -> each accepted only in IDLE; results match the model in order; o_add_* stay 0 outside RUN.
